// File: rtl/sqrt_share_arbiter_pkg.sv
// Shared definitions for the sqrt sharing arbiter: FSM state encoding,
// parameter defaults and the requester-ID width helper.
package sqrt_share_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   localparam int unsigned N_REQ_DEF   = 4;
   localparam int unsigned DATA_W_DEF  = 16;
   localparam int unsigned ROOT_W_DEF  = 8;
   localparam int unsigned TIMEOUT_DEF = 64;

   // Requester ID width; a single lane still needs a 1-bit ID field.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sqrt_share_arbiter_rr_grant.sv
// Round-robin priority picker (combinational).
// Ports:
//   valid     - per-lane request vector
//   ptr       - lane with highest priority this cycle
//   grant     - one-hot grant (zero when nothing is valid)
//   idx       - encoded index of the granted lane
//   any_valid - at least one lane is requesting
module sqrt_share_arbiter_rr_grant #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  idx,
   output logic             any_valid
);

   logic [ID_W-1:0] k;

   // Scan from ptr upward with wrap; the first valid lane wins.
   always_comb begin
      grant     = '0;
      idx       = '0;
      any_valid = 1'b0;
      k         = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         k = ID_W'((32'(ptr) + i) % N_REQ);
         if (!any_valid && valid[k]) begin
            any_valid = 1'b1;
            grant[k]  = 1'b1;
            idx       = k;
         end
      end
   end

endmodule

// File: rtl/sqrt_share_arbiter.sv
// Shares one sqrt unit between N_REQ lanes: round-robin accept, start/done
// sequencing with a watchdog, and an ID-tagged response.
// Ports:
//   i_clk, i_rstn             - clock, async active-low reset
//   i_req_valid/i_req_data    - per-lane request (lane k at [k*DATA_W +: DATA_W])
//   o_req_ready               - per-lane accept, one-hot or zero, same cycle
//   o_sqrt_start/o_sqrt_data  - request to the sqrt unit
//   i_sqrt_done/i_sqrt_root   - result from the sqrt unit
//   o_rsp_valid/id/root/err   - response, held until i_rsp_ready
//   o_busy                    - any state other than IDLE
module sqrt_share_arbiter
   import sqrt_share_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ   = N_REQ_DEF,
   parameter int unsigned ID_W    = id_width(N_REQ),
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned ROOT_W  = ROOT_W_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic [N_REQ-1:0]        i_req_valid,
   input  logic [N_REQ*DATA_W-1:0] i_req_data,
   output logic [N_REQ-1:0]        o_req_ready,
   output logic                    o_sqrt_start,
   output logic [DATA_W-1:0]       o_sqrt_data,
   input  logic                    i_sqrt_done,
   input  logic [ROOT_W-1:0]       i_sqrt_root,
   output logic                    o_rsp_valid,
   output logic [ID_W-1:0]         o_rsp_id,
   output logic [ROOT_W-1:0]       o_rsp_root,
   output logic                    o_rsp_err,
   input  logic                    i_rsp_ready,
   output logic                    o_busy
);

   localparam int unsigned     WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_e              state_q, state_n;
   logic [DATA_W-1:0]   data_q, data_n;
   logic [ID_W-1:0]     id_q, id_n;
   logic [ROOT_W-1:0]   root_q, root_n;
   logic                err_q, err_n;
   logic [WD_W-1:0]     wd_q, wd_n;
   logic [ID_W-1:0]     ptr_q, ptr_n;
   logic                start_q, rsp_valid_q, busy_q;

   logic [N_REQ-1:0]    grant;
   logic [ID_W-1:0]     grant_idx;
   logic                grant_any;
   logic [N_REQ-1:0]    req_ready_c;
   logic [DATA_W-1:0]   lane_data [N_REQ];

   // Unpack the flat request bus into per-lane words.
   for (genvar g = 0; g < N_REQ; g++) begin : g_lane
      assign lane_data[g] = i_req_data[g*DATA_W +: DATA_W];
   end

   sqrt_share_arbiter_rr_grant #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr_grant (
      .valid     (i_req_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .idx       (grant_idx),
      .any_valid (grant_any)
   );

   // Next-state, latch and watchdog logic.
   always_comb begin
      state_n     = state_q;
      data_n      = data_q;
      id_n        = id_q;
      root_n      = root_q;
      err_n       = err_q;
      wd_n        = wd_q;
      ptr_n       = ptr_q;
      req_ready_c = '0;
      case (state_q)
         ST_IDLE: begin
            if (grant_any) begin
               req_ready_c = grant;
               data_n      = lane_data[grant_idx];
               id_n        = grant_idx;
               state_n     = ST_START;
            end
         end
         ST_START: begin
            wd_n    = '0;
            state_n = ST_WAIT;
         end
         ST_WAIT: begin
            if (i_sqrt_done) begin
               root_n  = i_sqrt_root;
               err_n   = 1'b0;
               state_n = ST_RESP;
            end else if (wd_q == WD_LAST) begin
               root_n  = '1;
               err_n   = 1'b1;
               state_n = ST_RESP;
            end else begin
               wd_n = wd_q + WD_W'(1);
            end
         end
         ST_RESP: begin
            if (i_rsp_ready) begin
               ptr_n   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
               // Clearing here keeps o_sqrt_data at zero throughout IDLE.
               data_n  = '0;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // State, latches and registered outputs.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q     <= ST_IDLE;
         data_q      <= '0;
         id_q        <= '0;
         root_q      <= '0;
         err_q       <= 1'b0;
         wd_q        <= '0;
         ptr_q       <= '0;
         start_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_n;
         data_q      <= data_n;
         id_q        <= id_n;
         root_q      <= root_n;
         err_q       <= err_n;
         wd_q        <= wd_n;
         ptr_q       <= ptr_n;
         start_q     <= (state_n == ST_START);
         rsp_valid_q <= (state_n == ST_RESP);
         busy_q      <= (state_n != ST_IDLE);
      end
   end

   // Accept is same-cycle; held low while reset is asserted.
   assign o_req_ready  = req_ready_c & {N_REQ{i_rstn}};
   assign o_sqrt_start = start_q;
   assign o_sqrt_data  = data_q;
   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_id     = id_q;
   assign o_rsp_root   = root_q;
   assign o_rsp_err    = err_q;
   assign o_busy       = busy_q;

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// Self-checking bench for sqrt_share_arbiter with a behavioural sqrt unit.
module tb_sqrt_share_arbiter;

   logic        clk;
   logic        rstn;
   logic [3:0]  req_valid;
   logic [63:0] req_data;
   logic [3:0]  req_ready;
   logic        sqrt_start;
   logic [15:0] sqrt_data;
   logic        sqrt_done;
   logic [7:0]  sqrt_root;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_root;
   logic        rsp_err;
   logic        rsp_ready;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   sqrt_share_arbiter #(
      .N_REQ   (4),
      .TIMEOUT (8)
   ) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_req_valid  (req_valid),
      .i_req_data   (req_data),
      .o_req_ready  (req_ready),
      .o_sqrt_start (sqrt_start),
      .o_sqrt_data  (sqrt_data),
      .i_sqrt_done  (sqrt_done),
      .i_sqrt_root  (sqrt_root),
      .o_rsp_valid  (rsp_valid),
      .o_rsp_id     (rsp_id),
      .o_rsp_root   (rsp_root),
      .o_rsp_err    (rsp_err),
      .i_rsp_ready  (rsp_ready),
      .o_busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural sqrt unit: done sq_lat cycles after start, or never when hung.
   int          sq_lat  = 3;
   bit          sq_hang = 1'b0;
   int          sq_cnt;
   bit          sq_run;
   logic [15:0] sq_arg;

   function automatic logic [7:0] isqrt(input logic [15:0] x);
      int r = 0;
      while ((r + 1) * (r + 1) <= int'(x)) r++;
      return 8'(r);
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sqrt_done <= 1'b0;
         sqrt_root <= '0;
         sq_run    <= 1'b0;
         sq_cnt    <= 0;
         sq_arg    <= '0;
      end else begin
         sqrt_done <= 1'b0;
         if (sqrt_start && !sq_hang) begin
            sq_run <= 1'b1;
            sq_cnt <= sq_lat - 1;
            sq_arg <= sqrt_data;
         end else if (sq_run) begin
            if (sq_cnt <= 1) begin
               sqrt_done <= 1'b1;
               sqrt_root <= isqrt(sq_arg);
               sq_run    <= 1'b0;
            end else begin
               sq_cnt <= sq_cnt - 1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_lane(input logic [1:0] lane, input logic v, input logic [15:0] d);
      req_valid[lane]             = v;
      req_data[{lane, 4'b0} +: 16] = d;
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_ready"},  32'(req_ready), 0);
      chk({tag, "_start"},  32'(sqrt_start), 0);
      chk({tag, "_sdata"},  32'(sqrt_data), 0);
      chk({tag, "_rvalid"}, 32'(rsp_valid), 0);
      chk({tag, "_rid"},    32'(rsp_id), 0);
      chk({tag, "_rroot"},  32'(rsp_root), 0);
      chk({tag, "_rerr"},   32'(rsp_err), 0);
      chk({tag, "_busy"},   32'(busy), 0);
   endtask

   task automatic do_reset(input string tag);
      rstn      = 1'b0;
      rsp_ready = 1'b0;
      @(negedge clk); #1;
      check_idle_zero(tag);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // One full transaction. Called mid-cycle with lane inputs already driven.
   // exp_root < 0 selects the floor-sqrt property check instead of a constant.
   // bp = number of clock edges with i_rsp_ready low while in RESP.
   task automatic run_txn(input logic [3:0] exp_oh, input logic [15:0] exp_data,
                          input int exp_root, input logic exp_err, input int bp,
                          input bit drop, input string tag, output int lat);
      bit         got;
      logic [1:0] id;
      logic [7:0] root0;
      int         r, d;
      got = 1'b0;
      lat = 0;
      id  = '0;
      for (int i = 0; i < 4; i++) if (exp_oh[i]) id = 2'(i);
      for (int w = 0; w < 30; w++) begin
         #1;
         if (req_ready != 4'b0) begin got = 1'b1; break; end
         @(negedge clk);
      end
      chk({tag, "_grant_seen"}, 32'(got), 1);
      if (!got) return;
      chk({tag, "_ready"}, 32'(req_ready), 32'(exp_oh));
      @(negedge clk);
      if (drop) req_valid[id] = 1'b0;
      #1;
      chk({tag, "_start"}, 32'(sqrt_start), 1);
      chk({tag, "_sdata"}, 32'(sqrt_data), 32'(exp_data));
      chk({tag, "_busy"},  32'(busy), 1);
      got = 1'b0;
      for (int w = 1; w <= 40; w++) begin
         @(negedge clk); #1;
         if (rsp_valid) begin got = 1'b1; lat = w; break; end
         chk({tag, "_wait_ready"}, 32'(req_ready), 0);
      end
      chk({tag, "_rsp_seen"}, 32'(got), 1);
      if (!got) return;
      chk({tag, "_id"},  32'(rsp_id), 32'(id));
      chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
      if (exp_root >= 0) begin
         chk({tag, "_root"}, 32'(rsp_root), 32'(exp_root));
      end else begin
         r = int'(rsp_root);
         d = int'(exp_data);
         chk({tag, "_root_floor"}, 32'((r * r <= d) && ((r + 1) * (r + 1) > d)), 1);
      end
      root0 = rsp_root;
      for (int b = 0; b < bp; b++) begin
         @(negedge clk); #1;
         chk({tag, "_bp_valid"}, 32'(rsp_valid), 1);
         chk({tag, "_bp_id"},    32'(rsp_id), 32'(id));
         chk({tag, "_bp_root"},  32'(rsp_root), 32'(root0));
         chk({tag, "_bp_ready"}, 32'(req_ready), 0);
         chk({tag, "_bp_start"}, 32'(sqrt_start), 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      chk({tag, "_rel_valid"}, 32'(rsp_valid), 0);
      chk({tag, "_rel_busy"},  32'(busy), 0);
      chk({tag, "_rel_sdata"}, 32'(sqrt_data), 0);
   endtask

   // Round-robin rule: first requesting lane at or after ptr, wrapping.
   function automatic int exp_grant(input logic [3:0] v, input int p);
      logic [1:0] j;
      for (int i = 0; i < 4; i++) begin
         j = 2'((p + i) % 4);
         if (v[j]) return int'(j);
      end
      return -1;
   endfunction

   typedef struct {
      logic [15:0] data;
      logic [7:0]  root;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int          lat;
      int          g;
      int          m_ptr;
      logic [1:0]  gl;
      logic [1:0]  ln;
      logic [15:0] lane_d [4];

      vecs[0] = '{16'd4000,  8'd63};
      vecs[1] = '{16'd1000,  8'd31};
      vecs[2] = '{16'd40000, 8'd200};
      vecs[3] = '{16'd100,   8'd10};
      vecs[4] = '{16'd4,     8'd2};
      vecs[5] = '{16'd5326,  8'd72};
      vecs[6] = '{16'd11094, 8'd105};

      rstn      = 1'b0;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b0;

      // Reset with a lane already requesting: no accept may leak out.
      set_lane(2'd0, 1'b1, vecs[0].data);
      do_reset("rst0");

      // Single lane, table driven; first one also checks minimum turnaround.
      sq_lat = 3;
      for (int i = 0; i < 7; i++) begin
         set_lane(2'd0, 1'b1, vecs[i].data);
         run_txn(4'b0001, vecs[i].data, int'(vecs[i].root), 1'b0, 0, 1'b1, "single", lat);
         if (i == 0) chk("single_latency", 32'(lat), 32'(sq_lat + 1));
      end

      // All four lanes at once after reset: lane 0 first, then in order.
      req_valid = '0;
      do_reset("rst1");
      for (int i = 0; i < 4; i++) set_lane(2'(i), 1'b1, vecs[i].data);
      for (int i = 0; i < 4; i++)
         run_txn(4'b0001 << i, vecs[i].data, int'(vecs[i].root), 1'b0, 0, 1'b1, "all4", lat);

      // Fairness: lanes 1 and 3 held continuously.
      req_valid = '0;
      do_reset("rst2");
      set_lane(2'd1, 1'b1, 16'd4);
      set_lane(2'd3, 1'b1, 16'd100);
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) run_txn(4'b0010, 16'd4,   2,  1'b0, 0, 1'b0, "fair", lat);
         else            run_txn(4'b1000, 16'd100, 10, 1'b0, 0, 1'b0, "fair", lat);
      end

      // Back-pressure: 10 cycles held off with lane 1 waiting behind lane 0.
      req_valid = '0;
      do_reset("rst3");
      set_lane(2'd0, 1'b1, 16'd1000);
      set_lane(2'd1, 1'b1, 16'd4);
      run_txn(4'b0001, 16'd1000, 31, 1'b0, 10, 1'b1, "bp", lat);
      chk("bp_next_grant", 32'(req_ready), 32'(4'b0010));
      run_txn(4'b0010, 16'd4, 2, 1'b0, 0, 1'b1, "bp2", lat);

      // Timeout: hung sqrt unit, then a normal request afterwards.
      req_valid = '0;
      do_reset("rst4");
      sq_hang = 1'b1;
      set_lane(2'd0, 1'b1, 16'd1234);
      run_txn(4'b0001, 16'd1234, 255, 1'b1, 0, 1'b1, "tmo", lat);
      chk("tmo_latency", 32'(lat), 9);
      sq_hang = 1'b0;
      set_lane(2'd1, 1'b1, 16'd4000);
      run_txn(4'b0010, 16'd4000, 63, 1'b0, 0, 1'b1, "after_tmo", lat);

      // Reset during lane 2's computation abandons it silently.
      req_valid = '0;
      do_reset("rst5");
      sq_lat = 5;
      set_lane(2'd2, 1'b1, 16'd40000);
      #1;
      chk("mid_grant", 32'(req_ready), 32'(4'b0100));
      @(negedge clk);
      set_lane(2'd2, 1'b0, 16'd0);
      #1;
      chk("mid_start", 32'(sqrt_start), 1);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check_idle_zero("mid_rst");
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         chk("mid_no_rsp", 32'(rsp_valid), 0);
      end
      sq_lat = 3;
      set_lane(2'd0, 1'b1, 16'd100);
      run_txn(4'b0001, 16'd100, 10, 1'b0, 0, 1'b1, "post_rst", lat);

      // Randomized traffic against the round-robin rule.
      req_valid = '0;
      do_reset("rst6");
      m_ptr = 0;
      for (int i = 0; i < 4; i++) lane_d[i] = '0;
      for (int t = 0; t < 40; t++) begin
         for (int l = 0; l < 4; l++) begin
            ln = 2'(l);
            if (!req_valid[ln] && $urandom_range(0, 1) == 1) begin
               lane_d[l] = 16'($urandom);
               set_lane(ln, 1'b1, lane_d[l]);
            end
         end
         if (req_valid == 4'b0) begin
            ln = 2'($urandom_range(0, 3));
            lane_d[ln] = 16'($urandom);
            set_lane(ln, 1'b1, lane_d[ln]);
         end
         g  = exp_grant(req_valid, m_ptr);
         gl = 2'(g);
         sq_lat = int'($urandom_range(2, 6));
         run_txn(4'b0001 << gl, lane_d[gl], -1, 1'b0, int'($urandom_range(0, 3)),
                 1'b1, "rand", lat);
         m_ptr = (g + 1) % 4;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
